obstacle_scheduler: RTL and testbench
=====================================

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 SHALL have parameter SPAWN_TICKS, default 60, meaning frame ticks between spawn attempts.
REQ-002 SHALL have parameter SCROLL_STEP, default 4, meaning pixels moved left per frame tick.
REQ-003 SHALL have parameter OBS_WIDTH, default 40, meaning the obstacle width in pixels.
REQ-004 SHALL have parameter SPAWN_X, default 640, meaning the x_left of a newly spawned obstacle.
REQ-005 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port gamemode  input  2  game state: 00 init, 01 playing, 10 paused, 11 game over.
REQ-008 SHALL have port tick  input  1  single-cycle frame pulse.
REQ-009 SHALL have port obstacle_x  output  200  slot i: [20i+19:20i+10]=x_left and [20i+9:20i]=x_right, both 10-bit.
REQ-010 SHALL have port obstacle_y  output  180  slot i: [18i+17:18i+9]=y_top and [18i+8:18i]=y_bottom, both 9-bit.
REQ-011 SHALL have port active  output  10  bit i high when slot i holds a live obstacle.
REQ-012 SHALL have port passed_cnt  output  16  count of retired obstacles, saturating at 65535.

Function
REQ-013 SHALL register all outputs; an inactive slot SHALL drive all-zero x and y fields.
REQ-014 SHALL act only in cycles where tick=1; with tick=0 all state holds.
REQ-015 gamemode 00 SHALL clear every slot, active, spawn counter and passed_cnt on each clock, tick or not; LFSR holds.
REQ-016 gamemode 10 and 11 SHALL freeze all state: slots, counter, LFSR and passed_cnt.
REQ-017 gamemode 01 with tick=1 SHALL perform, in the same cycle: scroll, retire, spawn-counter update, and a possible spawn.
REQ-018 Scroll: each slot active before the tick with x_right > SCROLL_STEP SHALL get x_right -= SCROLL_STEP and x_left = max(x_left - SCROLL_STEP, 0).
REQ-019 Retire: each slot active before the tick with x_right <= SCROLL_STEP SHALL clear its active bit, zero its fields and increment passed_cnt once; simultaneous retirements SHALL add their count in one cycle, still saturating.
REQ-020 Spawn counter (6+ bits as needed) SHALL increment per playing tick and, on reaching SPAWN_TICKS-1, wrap to 0 and raise a spawn request in that cycle.
REQ-021 Spawn SHALL target the lowest-index slot inactive before this tick; a slot retiring in this tick is not eligible until the next tick.
REQ-022 Spawned slot SHALL take x_left=SPAWN_X, x_right=SPAWN_X+OBS_WIDTH, y_top={1'b0,lfsr[7:0]}+40, y_bottom=y_top+120, and SHALL not be scrolled in its spawn cycle.
REQ-023 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1; y values use the pre-advance value and the LFSR advances once per successful spawn only.
REQ-024 If all 10 slots are active at a spawn request, the spawn SHALL be dropped: no slot change, LFSR not advanced, and the counter still wraps.
REQ-025 y_top range SHALL be 40..295 and y_bottom 160..415, so no 9-bit overflow.
REQ-026 SPAWN_X+OBS_WIDTH SHALL be at most 1023; out-of-range parameters are unsupported.

Reset
REQ-027 rst_n=0 SHALL asynchronously zero obstacle_x, obstacle_y, active, passed_cnt and the spawn counter, and load LFSR=16'hACE1.
REQ-028 Reset asserted mid-play SHALL abandon all slots immediately; first activity after release follows REQ-015..REQ-017 from a clean state.

Verification
REQ-029 SPAWN_TICKS=4, gamemode=01, 4 ticks -> after the 4th tick active=10'b1, slot0 x={640,680} and y={265,385}; LFSR != 16'hACE1.
REQ-030 Continue 1 more tick -> slot0 x={636,676}; next spawn lands in slot1 on the 8th tick with y derived from the advanced LFSR.
REQ-031 gamemode=10 for 20 ticks, then 01 -> outputs unchanged during pause; scrolling resumes by exactly 4 px per tick.
REQ-032 Fill all 10 slots, then trigger a spawn request -> active stays 10'h3FF, LFSR unchanged, counter wraps to 0.
REQ-033 Run until slot0 x_right <= 4 at a tick -> slot0 zeroed, active[0]=0, passed_cnt=1; a spawn on the same tick goes to another free slot, not slot0.
REQ-034 gamemode 11 then 00 -> frozen during 11; on 00 all outputs zero within one clock; rst_n pulse mid-play zeros outputs without waiting for clk.

Source files
------------

// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - ten-slot scrolling obstacle scheduler with LFSR-driven vertical placement
module obstacle_scheduler #(
    parameter int SPAWN_TICKS = 60,
    parameter int SCROLL_STEP = 4,
    parameter int OBS_WIDTH   = 40,
    parameter int SPAWN_X     = 640
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   gamemode,
    input  logic         tick,
    output logic [199:0] obstacle_x,
    output logic [179:0] obstacle_y,
    output logic [9:0]   active,
    output logic [15:0]  passed_cnt
);

    localparam int NSLOT = 10;
    localparam int CW    = ($clog2(SPAWN_TICKS) > 6) ? $clog2(SPAWN_TICKS) : 6;

    localparam logic [CW-1:0] CNT_LAST  = CW'(SPAWN_TICKS - 1);
    localparam logic [9:0]    STEP      = 10'(SCROLL_STEP);
    localparam logic [9:0]    X_LEFT0   = 10'(SPAWN_X);
    localparam logic [9:0]    X_RIGHT0  = 10'(SPAWN_X + OBS_WIDTH);
    localparam logic [15:0]   LFSR_SEED = 16'hACE1;

    localparam logic [1:0] GM_INIT = 2'b00;
    localparam logic [1:0] GM_PLAY = 2'b01;

    logic [9:0]    xl_q [NSLOT];
    logic [9:0]    xr_q [NSLOT];
    logic [8:0]    yt_q [NSLOT];
    logic [8:0]    yb_q [NSLOT];
    logic [9:0]    xl_d [NSLOT];
    logic [9:0]    xr_d [NSLOT];
    logic [8:0]    yt_d [NSLOT];
    logic [8:0]    yb_d [NSLOT];
    logic [9:0]    active_d;
    logic [15:0]   passed_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [15:0]   lfsr_q;
    logic [15:0]   lfsr_d;

    logic          spawn_req;
    logic          free_found;
    logic [3:0]    free_slot;
    logic [3:0]    retire_n;
    logic [16:0]   passed_sum;
    logic [8:0]    spawn_yt;

    // Slot registers drive the packed output buses directly.
    for (genvar g = 0; g < NSLOT; g++) begin : g_pack
        assign obstacle_x[20*g +: 20] = {xl_q[g], xr_q[g]};
        assign obstacle_y[18*g +: 18] = {yt_q[g], yb_q[g]};
    end

    assign spawn_yt = {1'b0, lfsr_q[7:0]} + 9'd40;

    // Next-state: clear in init, scroll/retire/count/spawn on a playing tick, hold otherwise.
    always_comb begin
        xl_d       = xl_q;
        xr_d       = xr_q;
        yt_d       = yt_q;
        yb_d       = yb_q;
        active_d   = active;
        passed_d   = passed_cnt;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;
        spawn_req  = 1'b0;
        free_found = 1'b0;
        free_slot  = 4'd0;
        retire_n   = 4'd0;
        passed_sum = 17'd0;

        case (gamemode)
            GM_INIT: begin
                for (int i = 0; i < NSLOT; i++) begin
                    xl_d[i] = '0;
                    xr_d[i] = '0;
                    yt_d[i] = '0;
                    yb_d[i] = '0;
                end
                active_d = '0;
                passed_d = '0;
                cnt_d    = '0;
            end
            GM_PLAY: begin
                if (tick) begin
                    for (int i = 0; i < NSLOT; i++) begin
                        if (active[i]) begin
                            if (xr_q[i] > STEP) begin
                                xr_d[i] = xr_q[i] - STEP;
                                xl_d[i] = (xl_q[i] > STEP) ? (xl_q[i] - STEP) : 10'd0;
                            end else begin
                                xl_d[i]     = '0;
                                xr_d[i]     = '0;
                                yt_d[i]     = '0;
                                yb_d[i]     = '0;
                                active_d[i] = 1'b0;
                                retire_n    = retire_n + 4'd1;
                            end
                        end
                    end

                    passed_sum = {1'b0, passed_cnt} + {13'd0, retire_n};
                    passed_d   = passed_sum[16] ? 16'hFFFF : passed_sum[15:0];

                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        spawn_req = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end

                    // Eligibility uses the pre-tick active mask, so a slot retiring now stays empty this tick.
                    for (int i = 0; i < NSLOT; i++) begin
                        if (!active[i] && !free_found) begin
                            free_found = 1'b1;
                            free_slot  = 4'(i);
                        end
                    end

                    if (spawn_req && free_found) begin
                        for (int i = 0; i < NSLOT; i++) begin
                            if (free_slot == 4'(i)) begin
                                xl_d[i]     = X_LEFT0;
                                xr_d[i]     = X_RIGHT0;
                                yt_d[i]     = spawn_yt;
                                yb_d[i]     = spawn_yt + 9'd120;
                                active_d[i] = 1'b1;
                            end
                        end
                        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // State register with asynchronous clear of every slot and reseed of the LFSR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                xl_q[i] <= '0;
                xr_q[i] <= '0;
                yt_q[i] <= '0;
                yb_q[i] <= '0;
            end
            active     <= '0;
            passed_cnt <= '0;
            cnt_q      <= '0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                xl_q[i] <= xl_d[i];
                xr_q[i] <= xr_d[i];
                yt_q[i] <= yt_d[i];
                yb_q[i] <= yb_d[i];
            end
            active     <= active_d;
            passed_cnt <= passed_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - scoreboard bench for obstacle_scheduler
module tb_obstacle_scheduler;

    localparam int M_SPAWN = 4;

    logic         clk;
    logic         rst_n;
    logic [1:0]   gamemode;
    logic         tick;
    logic [199:0] obstacle_x;
    logic [179:0] obstacle_y;
    logic [9:0]   active;
    logic [15:0]  passed_cnt;

    logic [1:0]   gm2;
    logic         tick2;
    logic [199:0] ox2;
    logic [179:0] oy2;
    logic [9:0]   act2;
    logic [15:0]  pc2;

    int vectors;
    int miscompares;

    typedef struct {
        logic [199:0] x;
        logic [179:0] y;
        logic [9:0]   act;
        logic [15:0]  pc;
    } exp_t;

    exp_t sb[$];

    int          m_xl [10];
    int          m_xr [10];
    int          m_yt [10];
    int          m_yb [10];
    logic [9:0]  m_act;
    int          m_passed;
    int          m_cnt;
    logic [15:0] m_lfsr;

    obstacle_scheduler #(.SPAWN_TICKS(M_SPAWN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gamemode   (gamemode),
        .tick       (tick),
        .obstacle_x (obstacle_x),
        .obstacle_y (obstacle_y),
        .active     (active),
        .passed_cnt (passed_cnt)
    );

    obstacle_scheduler #(.SPAWN_TICKS(34)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .gamemode   (gm2),
        .tick       (tick2),
        .obstacle_x (ox2),
        .obstacle_y (oy2),
        .active     (act2),
        .passed_cnt (pc2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_xl[i] = 0; m_xr[i] = 0; m_yt[i] = 0; m_yb[i] = 0;
        end
        m_act    = '0;
        m_passed = 0;
        m_cnt    = 0;
        m_lfsr   = 16'hACE1;
    endtask

    task automatic model_step(input logic [1:0] gm, input logic t);
        logic [9:0] pre;
        int slot;
        if (gm == 2'b00) begin
            for (int i = 0; i < 10; i++) begin
                m_xl[i] = 0; m_xr[i] = 0; m_yt[i] = 0; m_yb[i] = 0;
            end
            m_act    = '0;
            m_passed = 0;
            m_cnt    = 0;
        end else if (gm == 2'b01 && t) begin
            pre = m_act;
            for (int i = 0; i < 10; i++) begin
                if (pre[i]) begin
                    if (m_xr[i] > 4) begin
                        m_xr[i] = m_xr[i] - 4;
                        m_xl[i] = (m_xl[i] >= 4) ? m_xl[i] - 4 : 0;
                    end else begin
                        m_xl[i] = 0; m_xr[i] = 0; m_yt[i] = 0; m_yb[i] = 0;
                        m_act[i] = 1'b0;
                        if (m_passed < 65535) m_passed++;
                    end
                end
            end
            if (m_cnt == M_SPAWN - 1) begin
                m_cnt = 0;
                slot = -1;
                for (int i = 9; i >= 0; i--) if (!pre[i]) slot = i;
                if (slot >= 0) begin
                    m_xl[slot]  = 640;
                    m_xr[slot]  = 680;
                    m_yt[slot]  = int'(m_lfsr[7:0]) + 40;
                    m_yb[slot]  = m_yt[slot] + 120;
                    m_act[slot] = 1'b1;
                    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    function automatic exp_t model_pack();
        exp_t e;
        int xl, xr, yt, yb;
        for (int i = 0; i < 10; i++) begin
            xl = m_xl[i]; xr = m_xr[i]; yt = m_yt[i]; yb = m_yb[i];
            e.x[20*i +: 20] = {xl[9:0], xr[9:0]};
            e.y[18*i +: 18] = {yt[8:0], yb[8:0]};
        end
        e.act = m_act;
        e.pc  = m_passed[15:0];
        return e;
    endfunction

    task automatic do_cycle(input logic [1:0] gm, input logic t);
        exp_t e;
        gamemode = gm;
        tick     = t;
        model_step(gm, t);
        sb.push_back(model_pack());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_x", obstacle_x, e.x);
        chk("sb_y", obstacle_y, e.y);
        chk("sb_active", active, e.act);
        chk("sb_passed", passed_cnt, e.pc);
    endtask

    task automatic play(input int n);
        for (int k = 0; k < n; k++) do_cycle(2'b01, 1'b1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        gamemode    = 2'b00;
        tick        = 1'b0;
        gm2         = 2'b00;
        tick2       = 1'b0;
        model_reset();
        #1;
        chk("rst_x", obstacle_x, '0);
        chk("rst_y", obstacle_y, '0);
        chk("rst_active", active, '0);
        chk("rst_passed", passed_cnt, '0);
        chk("rst_active2", act2, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_cycle(2'b01, 1'b0);
        do_cycle(2'b01, 1'b0);
        play(4);
        chk("first_active", active, 10'h001);
        chk("first_x0", obstacle_x[19:0], {10'd640, 10'd680});
        chk("first_y0", obstacle_y[17:0], {9'd265, 9'd385});
        play(1);
        chk("scroll_x0", obstacle_x[19:0], {10'd636, 10'd676});
        do_cycle(2'b01, 1'b0);
        chk("hold_x0", obstacle_x[19:0], {10'd636, 10'd676});
        play(3);
        chk("second_active", active, 10'h003);
        chk("second_x1", obstacle_x[39:20], {10'd640, 10'd680});
        chk("second_y1", obstacle_y[35:18], {9'd235, 9'd355});
        chk("second_x0", obstacle_x[19:0], {10'd624, 10'd664});

        for (int k = 0; k < 20; k++) do_cycle(2'b10, 1'b1);
        chk("pause_x0", obstacle_x[19:0], {10'd624, 10'd664});
        chk("pause_active", active, 10'h003);
        play(1);
        chk("resume_x0", obstacle_x[19:0], {10'd620, 10'd660});

        play(31);
        chk("full_active", active, 10'h3FF);
        play(4);
        chk("drop_active", active, 10'h3FF);
        play(132);
        chk("retire_passed", passed_cnt, 16'd1);
        chk("respawn_x0", obstacle_x[19:0], {10'd640, 10'd680});

        for (int k = 0; k < 5; k++) do_cycle(2'b11, 1'b1);
        chk("over_passed", passed_cnt, 16'd1);
        do_cycle(2'b00, 1'b0);
        chk("init_x", obstacle_x, '0);
        chk("init_y", obstacle_y, '0);
        chk("init_active", active, '0);
        chk("init_passed", passed_cnt, '0);
        play(6);

        rst_n = 1'b0;
        #2;
        chk("async_rst_x", obstacle_x, '0);
        chk("async_rst_y", obstacle_y, '0);
        chk("async_rst_active", active, '0);
        model_reset();
        rst_n = 1'b1;
        play(4);
        chk("reseed_y0", obstacle_y[17:0], {9'd265, 9'd385});

        gm2   = 2'b01;
        tick2 = 1'b1;
        for (int k = 0; k < 203; k++) do_cycle(2'b10, 1'b0);
        chk("d2_pre_active", act2, 10'h01F);
        chk("d2_pre_x0", ox2[19:0], {10'd0, 10'd4});
        do_cycle(2'b10, 1'b0);
        chk("d2_ret_active", act2, 10'h03E);
        chk("d2_ret_passed", pc2, 16'd1);
        chk("d2_ret_x0", ox2[19:0], '0);
        chk("d2_ret_y0", oy2[17:0], '0);
        chk("d2_spawn_x5", ox2[119:100], {10'd640, 10'd680});
        tick2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
